// File: rtl/adaption_update_scheduler.sv
// Ambient-adaptation scheduler: periodic ALS reads, CCT hysteresis, stage timeouts and a
// double-buffered 3x3 matrix committed on frame boundaries (macro ADAPT_FRAME_SYNC_EN).
module adaption_update_scheduler #(
  parameter int REFRESH_PERIOD = 1000000,
  parameter int STAGE_TIMEOUT  = 65535,
  parameter int CCT_HYST       = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         force_update,
  input  logic         als_busy,
  output logic         als_read_req,
  input  logic [15:0]  cct_in,
  input  logic         cct_valid,
  input  logic [287:0] matrix_in,
  input  logic         matrix_valid,
  input  logic         frame_start,
  output logic [287:0] matrix_out,
  output logic         matrix_out_valid,
  output logic [2:0]   state_out,
  output logic         timeout_err,
  output logic [7:0]   update_count
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_WAIT_PERIOD = 3'd1;
  localparam logic [2:0] S_REQ         = 3'd2;
  localparam logic [2:0] S_WAIT_CCT    = 3'd3;
  localparam logic [2:0] S_WAIT_MATRIX = 3'd4;
  localparam logic [2:0] S_WAIT_FRAME  = 3'd5;
  localparam logic [2:0] S_COMMIT      = 3'd6;
  localparam logic [2:0] S_ERROR       = 3'd7;

  localparam int PERIOD_W = $clog2(REFRESH_PERIOD + 1);
  localparam int STAGE_W  = $clog2(STAGE_TIMEOUT + 1);

  localparam logic [31:0]  ONE_Q16  = 32'h0001_0000;
  localparam logic [287:0] IDENTITY = {ONE_Q16, 32'h0, 32'h0,
                                       32'h0, ONE_Q16, 32'h0,
                                       32'h0, 32'h0, ONE_Q16};

  logic [2:0]          state_q, state_d;
  logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
  logic [STAGE_W-1:0]  stage_cnt_q, stage_cnt_d;
  logic                req_q, req_d;
  logic                force_q, force_d;
  logic                timeout_q, timeout_d;
  logic                have_commit_q, have_commit_d;
  logic [15:0]         last_cct_q, last_cct_d;
  logic [15:0]         pending_cct_q, pending_cct_d;
  logic [7:0]          count_q, count_d;
  logic [287:0]        matrix_q, matrix_d;
  logic [287:0]        shadow_q;

`ifdef ADAPT_FRAME_SYNC_EN
  logic                armed_q, armed_d;
`else
  logic                unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

  logic signed [16:0]  cct_diff;
  logic [16:0]         cct_abs;
  logic                within_hyst;

  assign cct_diff    = $signed({1'b0, cct_in}) - $signed({1'b0, last_cct_q});
  assign cct_abs     = cct_diff[16] ? $unsigned(-cct_diff) : $unsigned(cct_diff);
  assign within_hyst = cct_abs < 17'(CCT_HYST);

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
    state_d       = state_q;
    period_cnt_d  = '0;
    stage_cnt_d   = stage_cnt_q;
    req_d         = 1'b0;
    force_d       = force_q;
    timeout_d     = timeout_q;
    have_commit_d = have_commit_q;
    last_cct_d    = last_cct_q;
    pending_cct_d = pending_cct_q;
    count_d       = count_q;
    matrix_d      = matrix_q;
`ifdef ADAPT_FRAME_SYNC_EN
    armed_d       = armed_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          if (force_update) begin
            state_d = S_REQ;
            force_d = 1'b1;
          end else begin
            state_d = S_WAIT_PERIOD;
          end
        end
      end
      S_WAIT_PERIOD: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (force_update) begin
          state_d = S_REQ;
          force_d = 1'b1;
        end else if (period_cnt_q == PERIOD_W'(REFRESH_PERIOD - 1)) begin
          state_d = S_REQ;
        end else begin
          period_cnt_d = period_cnt_q + 1'b1;
        end
      end
      S_REQ: begin
        if (!als_busy) begin
          req_d       = 1'b1;
          stage_cnt_d = '0;
          state_d     = S_WAIT_CCT;
        end
      end
      S_WAIT_CCT: begin
        if (cct_valid) begin
          if (have_commit_q && !force_q && within_hyst) begin
            state_d = S_WAIT_PERIOD;
          end else begin
            pending_cct_d = cct_in;
            stage_cnt_d   = '0;
            state_d       = S_WAIT_MATRIX;
          end
        end else if (stage_cnt_q == STAGE_W'(STAGE_TIMEOUT - 1)) begin
          state_d   = S_ERROR;
          timeout_d = 1'b1;
        end else begin
          stage_cnt_d = stage_cnt_q + 1'b1;
        end
      end
      S_WAIT_MATRIX: begin
        if (matrix_valid) begin
`ifdef ADAPT_FRAME_SYNC_EN
          state_d = S_WAIT_FRAME;
          armed_d = 1'b0;
`else
          state_d = S_COMMIT;
`endif
        end else if (stage_cnt_q == STAGE_W'(STAGE_TIMEOUT - 1)) begin
          state_d   = S_ERROR;
          timeout_d = 1'b1;
        end else begin
          stage_cnt_d = stage_cnt_q + 1'b1;
        end
      end
`ifdef ADAPT_FRAME_SYNC_EN
      S_WAIT_FRAME: begin
        // A frame_start on the entry cycle is ignored so the commit never lands mid-frame.
        armed_d = 1'b1;
        if (frame_start && armed_q) state_d = S_COMMIT;
      end
`endif
      S_COMMIT: begin
        matrix_d      = shadow_q;
        last_cct_d    = pending_cct_q;
        have_commit_d = 1'b1;
        count_d       = count_q + 1'b1;
        timeout_d     = 1'b0;
        force_d       = 1'b0;
        state_d       = enable ? S_WAIT_PERIOD : S_IDLE;
      end
      S_ERROR: begin
        force_d = 1'b0;
        state_d = enable ? S_WAIT_PERIOD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      period_cnt_q  <= '0;
      stage_cnt_q   <= '0;
      req_q         <= 1'b0;
      force_q       <= 1'b0;
      timeout_q     <= 1'b0;
      have_commit_q <= 1'b0;
      last_cct_q    <= '0;
      pending_cct_q <= '0;
      count_q       <= '0;
      matrix_q      <= IDENTITY;
`ifdef ADAPT_FRAME_SYNC_EN
      armed_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      stage_cnt_q   <= stage_cnt_d;
      req_q         <= req_d;
      force_q       <= force_d;
      timeout_q     <= timeout_d;
      have_commit_q <= have_commit_d;
      last_cct_q    <= last_cct_d;
      pending_cct_q <= pending_cct_d;
      count_q       <= count_d;
      matrix_q      <= matrix_d;
`ifdef ADAPT_FRAME_SYNC_EN
      armed_q       <= armed_d;
`endif
    end
  end

  // NOTE: the shadow matrix has no reset; COMMIT is only reachable after it has been loaded.
  always_ff @(posedge clk) begin
    if (state_q == S_WAIT_MATRIX && matrix_valid) shadow_q <= matrix_in;
  end

  assign als_read_req     = req_q;
  assign matrix_out       = matrix_q;
  // matrix_out always holds a usable matrix (identity from reset), so valid is a constant level.
  assign matrix_out_valid = 1'b1;
  assign state_out        = state_q;
  assign timeout_err      = timeout_q;
  assign update_count     = count_q;

endmodule

// File: doc/adaption_update_scheduler.md
Name: adaption_update_scheduler

Overview:
- Sequences the ambient-adaptation loop: requests periodic ALS reads, tracks the CCT → XYZ → Bradford matrix pipeline through its valid strobes, and guards each stage with a timeout.
- Applies CCT hysteresis so small ambient changes do not trigger a matrix update.
- Double-buffers the 3x3 compensation matrix and commits it to the pixel path only on a frame boundary, so no frame mixes two matrices.
- Sits between the ALS interface, the Bradford block and the image processor; replaces direct wiring of matrix_valid to the pixel path.

Parameters:
- REFRESH_PERIOD, 1000000: cycles spent in WAIT_PERIOD between ALS read requests (minimum 2).
- STAGE_TIMEOUT, 65535: maximum cycles allowed in WAIT_CCT or WAIT_MATRIX before an error is flagged.
- CCT_HYST, 100: minimum CCT change, in Kelvin, that triggers a matrix update.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  scheduler run enable
- force_update  in  1  pulse; start a sequence now and bypass hysteresis for it
- als_busy  in  1  ALS interface busy
- als_read_req  out  1  single-cycle ALS read request
- cct_in  in  16  ambient CCT in Kelvin, unsigned
- cct_valid  in  1  cct_in valid strobe
- matrix_in  in  288  Bradford output matrix: 9 x 32-bit Q16.16, row-major, element i at [32i+31:32i]
- matrix_valid  in  1  matrix_in valid strobe
- frame_start  in  1  single-cycle start-of-frame pulse from the pixel path
- matrix_out  out  288  committed matrix to image_processor
- matrix_out_valid  out  1  committed matrix valid, level signal
- state_out  out  3  current FSM state code
- timeout_err  out  1  sticky stage-timeout flag
- update_count  out  8  number of commits, wraps modulo 256

Behaviour:
- Reset values:
  - matrix_out = identity (elements 0, 4, 8 = 32'h00010000; all others 0).
  - matrix_out_valid = 1, als_read_req = 0, timeout_err = 0, update_count = 0, state = IDLE.
  - Internal: last_cct = 0, have_commit = 0, all counters = 0.
- State codes: IDLE=0, WAIT_PERIOD=1, REQ=2, WAIT_CCT=3, WAIT_MATRIX=4, WAIT_FRAME=5, COMMIT=6, ERROR=7.
- IDLE:
  - enable=1 → WAIT_PERIOD with the period counter cleared.
  - force_update=1 (with enable=1) → REQ directly.
- WAIT_PERIOD:
  - Counter increments each cycle; at REFRESH_PERIOD-1 → REQ.
  - force_update → REQ next cycle and set the force flag.
  - enable=0 → IDLE.
- REQ:
  - While als_busy=1, hold with als_read_req=0.
  - First cycle with als_busy=0: als_read_req=1 for exactly that cycle, clear the stage counter, → WAIT_CCT.
- WAIT_CCT, on cct_valid:
  - If have_commit=1, force flag=0 and |cct_in - last_cct| < CCT_HYST → WAIT_PERIOD (skip). Subtraction is 17-bit signed, then absolute value.
  - Otherwise latch pending_cct = cct_in and → WAIT_MATRIX (stage counter cleared).
- WAIT_MATRIX, on matrix_valid:
  - Latch matrix_in into the shadow register and → WAIT_FRAME.
  - A matrix_valid seen in any other state is ignored.
- Timeouts:
  - In WAIT_CCT and WAIT_MATRIX the stage counter increments each cycle.
  - Reaching STAGE_TIMEOUT → ERROR; timeout_err is set.
- WAIT_FRAME:
  - The first frame_start sampled while in this state → COMMIT.
  - A frame_start coinciding with the entry cycle into WAIT_FRAME does not count.
- COMMIT (one cycle):
  - matrix_out <= shadow; last_cct <= pending_cct; have_commit <= 1; update_count += 1; timeout_err <= 0; force flag cleared.
  - The new matrix_out is visible the cycle after COMMIT.
  - → WAIT_PERIOD, or IDLE if enable=0.
- ERROR (one cycle): force flag cleared; → WAIT_PERIOD (retry next period), or IDLE if enable=0.
- matrix_out is never altered except in COMMIT and at reset. A partially received sequence never disturbs it.
- enable dropped mid-sequence (states REQ..WAIT_FRAME): the sequence completes or times out, then → IDLE.
- force_update in any state other than IDLE or WAIT_PERIOD is ignored.
- Reset asserted mid-sequence: everything returns to reset values immediately; the pending shadow matrix is discarded.

Optional Feature:
- Macro: ADAPT_FRAME_SYNC_EN.
- Defined: behaviour as above; commits wait for frame_start in WAIT_FRAME.
- Not defined: WAIT_FRAME is skipped; WAIT_MATRIX → COMMIT directly on matrix_valid. frame_start is unused and state 5 is never entered.

Test Plan (REFRESH_PERIOD=16, STAGE_TIMEOUT=32, CCT_HYST=100, ADAPT_FRAME_SYNC_EN defined):
- Reset release, enable=1 → matrix_out = identity and matrix_out_valid=1 throughout; als_read_req pulses exactly one cycle, 17 cycles after entering WAIT_PERIOD.
- Full sequence:
  - Stimulus: cct_in=4000 with cct_valid, then matrix_valid with matrix_in = all 32'h00008000, then frame_start 5 cycles later.
  - Response: matrix_out unchanged until the cycle after COMMIT, then holds the new matrix; update_count=1.
- Hysteresis skip:
  - After a commit at 4000, the next read returns 4050 → no WAIT_MATRIX, matrix_out and update_count unchanged.
  - Same stimulus with force_update asserted in WAIT_PERIOD → commit occurs, update_count=2.
- Timeout: no cct_valid after als_read_req → ERROR after 32 cycles; timeout_err=1; the next successful commit clears it.
- Busy and race: als_busy held high 10 cycles in REQ → als_read_req withheld, then a single pulse; frame_start on the WAIT_FRAME entry cycle → no commit until the next frame_start.
- Reset mid-sequence: rst asserted in WAIT_FRAME → matrix_out returns to identity and update_count=0 asynchronously.
